// File: rtl/dpad2analog_if.sv
// D-pad / analog-stick bus: registered-side inputs (enable, D-pad) and the
// converted analog axis outputs with their status flags.
interface dpad2analog_if;
  logic       enable;
  logic       dpad_up;
  logic       dpad_down;
  logic       dpad_left;
  logic       dpad_right;
  logic [7:0] joy_lx;
  logic [7:0] joy_ly;
  logic       changed;
  logic       settled;

  modport master (
    output enable, dpad_up, dpad_down, dpad_left, dpad_right,
    input  joy_lx, joy_ly, changed, settled
  );

  modport slave (
    input  enable, dpad_up, dpad_down, dpad_left, dpad_right,
    output joy_lx, joy_ly, changed, settled
  );
endinterface

// File: rtl/dpad2analog.sv
// D-pad to analog-stick converter: per-axis ramp toward a target on each prescaler tick.
// Optional macro DPAD2ANALOG_DIAG_SCALE_EN scales diagonal targets to ~0.707 magnitude.
//   state    | meaning
//   CENTERED | axis value equals target, target is CENTER
//   RAMPING  | axis value differs from its target
//   HELD     | axis value equals a non-CENTER target
module dpad2analog #(
  parameter logic [7:0]  CENTER   = 8'h80,
  parameter logic [7:0]  STEP     = 8'h10,
  parameter logic [15:0] TICK_DIV = 16'd4
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  dpad2analog_if.slave bus
);

  typedef enum logic [1:0] {CENTERED, RAMPING, HELD} axis_state_e;

`ifdef DPAD2ANALOG_DIAG_SCALE_EN
  localparam logic [7:0] DIAG_HI = CENTER + 8'h5B;
  localparam logic [7:0] DIAG_LO = CENTER - 8'h5B;
`endif

  logic        en_q, up_q, dn_q, lf_q, rt_q;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  lx_q, lx_d, ly_q, ly_d;
  logic        changed_q, changed_d;
  axis_state_e st_x_q, st_x_d, st_y_q, st_y_d;
  logic        tick;
  logic [7:0]  tgt_x, tgt_y, tgt_x_nx, tgt_y_nx;

  function automatic logic [7:0] axis_target(input logic en, input logic neg, input logic pos);
    logic [7:0] t;
    t = CENTER;
    if (en && pos && !neg)      t = 8'hFF;
    else if (en && neg && !pos) t = 8'h00;
    return t;
  endfunction

  // 9-bit compare so value+STEP / value-STEP never wraps past the target
  function automatic logic [7:0] axis_step(input logic [7:0] v, input logic [7:0] t);
    logic [8:0] v9, t9, s9;
    logic [7:0] r;
    v9 = {1'b0, v};
    t9 = {1'b0, t};
    s9 = {1'b0, STEP};
    r  = v;
    if (v9 < t9)      r = (v9 + s9 >= t9) ? t : 8'(v9 + s9);
    else if (v9 > t9) r = (v9 >= t9 + s9) ? 8'(v9 - s9) : t;
    return r;
  endfunction

  function automatic axis_state_e axis_next(input logic [7:0] v, input logic [7:0] t);
    axis_state_e s;
    s = RAMPING;
    if (v == t) s = (t == CENTER) ? CENTERED : HELD;
    return s;
  endfunction

  // Current targets come from the registered inputs; next targets from the
  // inputs about to be registered, so the state register tracks value vs target.
  always_comb begin
    tgt_x    = axis_target(en_q, lf_q, rt_q);
    tgt_y    = axis_target(en_q, up_q, dn_q);
    tgt_x_nx = axis_target(bus.enable, bus.dpad_left, bus.dpad_right);
    tgt_y_nx = axis_target(bus.enable, bus.dpad_up, bus.dpad_down);
`ifdef DPAD2ANALOG_DIAG_SCALE_EN
    if (tgt_x != CENTER && tgt_y != CENTER) begin
      tgt_x = (tgt_x == 8'hFF) ? DIAG_HI : DIAG_LO;
      tgt_y = (tgt_y == 8'hFF) ? DIAG_HI : DIAG_LO;
    end
    if (tgt_x_nx != CENTER && tgt_y_nx != CENTER) begin
      tgt_x_nx = (tgt_x_nx == 8'hFF) ? DIAG_HI : DIAG_LO;
      tgt_y_nx = (tgt_y_nx == 8'hFF) ? DIAG_HI : DIAG_LO;
    end
`endif
  end

  always_comb begin
    tick      = (presc_q == TICK_DIV - 16'd1);
    presc_d   = tick ? 16'd0 : 16'(presc_q + 16'd1);
    lx_d      = lx_q;
    ly_d      = ly_q;
    if (tick) begin
      lx_d = axis_step(lx_q, tgt_x);
      ly_d = axis_step(ly_q, tgt_y);
    end
    changed_d = (lx_d != lx_q) || (ly_d != ly_q);
    st_x_d    = axis_next(lx_d, tgt_x_nx);
    st_y_d    = axis_next(ly_d, tgt_y_nx);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      en_q      <= 1'b0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      lf_q      <= 1'b0;
      rt_q      <= 1'b0;
      presc_q   <= 16'd0;
      lx_q      <= CENTER;
      ly_q      <= CENTER;
      changed_q <= 1'b0;
      st_x_q    <= CENTERED;
      st_y_q    <= CENTERED;
    end else begin
      en_q      <= bus.enable;
      up_q      <= bus.dpad_up;
      dn_q      <= bus.dpad_down;
      lf_q      <= bus.dpad_left;
      rt_q      <= bus.dpad_right;
      presc_q   <= presc_d;
      lx_q      <= lx_d;
      ly_q      <= ly_d;
      changed_q <= changed_d;
      st_x_q    <= st_x_d;
      st_y_q    <= st_y_d;
    end
  end

  assign bus.joy_lx  = lx_q;
  assign bus.joy_ly  = ly_q;
  assign bus.changed = changed_q;
  assign bus.settled = (st_x_q != RAMPING) && (st_y_q != RAMPING);

endmodule

// File: tb/tb_dpad2analog.sv
// Bench for dpad2analog: directed vector table, hand sequences for ramp corners,
// and randomized D-pad activity checked every cycle against a cycle-level model.
module tb_dpad2analog;

  localparam int C  = 8'h80;
  localparam int S  = 8'h10;
  localparam int TD = 4;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  dpad2analog_if bus_a ();
  dpad2analog_if bus_b ();

  dpad2analog u_dut_a (.clk_sys(clk_sys), .reset_n(reset_n), .bus(bus_a));
  dpad2analog #(.CENTER(8'h80), .STEP(8'hFF), .TICK_DIV(16'd1))
    u_dut_b (.clk_sys(clk_sys), .reset_n(reset_n), .bus(bus_b));

  int total = 0;
  int bad   = 0;

  // model state
  bit m_en, m_u, m_d, m_l, m_r;
  int m_cnt, m_x, m_y;
  bit m_chg;

  typedef struct {
    bit en, u, d, l, r;
    int lx, ly, pulses;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dir_of(input bit en, input bit neg, input bit pos);
    if (!en || neg == pos) return 0;
    return pos ? 1 : -1;
  endfunction

  function automatic int tgt(input int dir, input int other_dir);
    if (dir == 0) return C;
`ifdef DPAD2ANALOG_DIAG_SCALE_EN
    if (other_dir != 0) return C + dir * 8'h5B;
`endif
    return (dir > 0) ? 255 : 0;
  endfunction

  function automatic int tx_m();
    return tgt(dir_of(m_en, m_l, m_r), dir_of(m_en, m_u, m_d));
  endfunction

  function automatic int ty_m();
    return tgt(dir_of(m_en, m_u, m_d), dir_of(m_en, m_l, m_r));
  endfunction

  function automatic int step_to(input int v, input int t);
    if (v < t) return (v + S > t) ? t : v + S;
    if (v > t) return (v - S < t) ? t : v - S;
    return v;
  endfunction

  task automatic model_edge();
    int nx, ny, tx, ty;
    if (!reset_n) begin
      {m_en, m_u, m_d, m_l, m_r} = '0;
      m_cnt = 0; m_x = C; m_y = C; m_chg = 0;
    end else begin
      tx = tx_m(); ty = ty_m();
      nx = m_x; ny = m_y;
      if (m_cnt == TD - 1) begin
        nx = step_to(m_x, tx);
        ny = step_to(m_y, ty);
      end
      m_chg = (nx != m_x) || (ny != m_y);
      m_x = nx; m_y = ny;
      m_cnt = (m_cnt + 1) % TD;
      m_en = bus_a.enable; m_u = bus_a.dpad_up; m_d = bus_a.dpad_down;
      m_l = bus_a.dpad_left; m_r = bus_a.dpad_right;
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    model_edge();
    #1;
    chk("lx", bus_a.joy_lx, m_x);
    chk("ly", bus_a.joy_ly, m_y);
    chk("changed", bus_a.changed, m_chg);
    chk("settled", bus_a.settled, (m_x == tx_m()) && (m_y == ty_m()));
  endtask

  task automatic drive(input bit en, input bit u, input bit d, input bit l, input bit r);
    bus_a.enable = en; bus_a.dpad_up = u; bus_a.dpad_down = d;
    bus_a.dpad_left = l; bus_a.dpad_right = r;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    int pulses, exp_v, n;
    bit found;

    tbl[0] = '{1, 0, 0, 0, 1, 8'hFF, 8'h80, 8};
    tbl[1] = '{1, 0, 0, 1, 0, 8'h00, 8'h80, 8};
    tbl[2] = '{1, 1, 0, 0, 0, 8'h80, 8'h00, 8};
    tbl[3] = '{1, 0, 1, 0, 0, 8'h80, 8'hFF, 8};
    tbl[4] = '{1, 0, 0, 1, 1, 8'h80, 8'h80, 0};
    tbl[5] = '{0, 0, 0, 0, 1, 8'h80, 8'h80, 0};
`ifdef DPAD2ANALOG_DIAG_SCALE_EN
    tbl[6] = '{1, 1, 0, 0, 1, 8'hDB, 8'h25, 6};
    tbl[7] = '{1, 0, 1, 1, 0, 8'h25, 8'hDB, 6};
`else
    tbl[6] = '{1, 1, 0, 0, 1, 8'hFF, 8'h00, 8};
    tbl[7] = '{1, 0, 1, 1, 0, 8'h00, 8'hFF, 8};
`endif

    drive(0, 0, 0, 0, 0);
    bus_b.enable = 1'b1; bus_b.dpad_up = 1'b0; bus_b.dpad_down = 1'b0;
    bus_b.dpad_left = 1'b0; bus_b.dpad_right = 1'b0;
    m_cnt = 0; m_x = C; m_y = C; m_chg = 0;

    // reset state
    do_reset();
    chk("rst_presc", int'(u_dut_a.presc_q), 0);
    chk("rst_settled", bus_a.settled, 1);

    // directed table, each vector starts from reset
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].en, tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].r);
      do_reset();
      pulses = 0;
      for (int k = 0; k < 80; k++) begin
        cyc();
        if (bus_a.changed) pulses++;
      end
      chk($sformatf("vec%0d_lx", i), bus_a.joy_lx, tbl[i].lx);
      chk($sformatf("vec%0d_ly", i), bus_a.joy_ly, tbl[i].ly);
      chk($sformatf("vec%0d_pulses", i), pulses, tbl[i].pulses);
      chk($sformatf("vec%0d_settled", i), bus_a.settled, 1);
    end

    // right held from reset: 0x90..0xF0 then 0xFF, settled only after last step
    drive(1, 0, 0, 0, 1);
    do_reset();
    exp_v = 8'h90; n = 0;
    for (int k = 0; k < 60; k++) begin
      cyc();
      if (bus_a.changed) begin
        chk("seq_right_val", bus_a.joy_lx, exp_v);
        chk("seq_right_settled", bus_a.settled, exp_v == 8'hFF);
        exp_v = (exp_v + 8'h10 > 8'hFF) ? 8'hFF : exp_v + 8'h10;
        n++;
      end
    end
    chk("seq_right_count", n, 8);

    // up to 0x40, then reverse to down with no detour through CENTER
    drive(1, 1, 0, 0, 0);
    do_reset();
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      cyc();
      if (bus_a.joy_ly == 8'h40) found = 1;
    end
    chk("rev_reach_40", found, 1);
    drive(1, 0, 1, 0, 0);
    exp_v = 8'h50; n = 0;
    for (int k = 0; k < 120; k++) begin
      cyc();
      if (bus_a.changed) begin
        chk("rev_val", bus_a.joy_ly, exp_v);
        exp_v = (exp_v + 8'h10 > 8'hFF) ? 8'hFF : exp_v + 8'h10;
        n++;
      end
    end
    chk("rev_count", n, 12);

    // reset mid-ramp at 0xB0
    drive(1, 0, 0, 0, 1);
    do_reset();
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      cyc();
      if (bus_a.joy_lx == 8'hB0) found = 1;
    end
    chk("midrst_reach_b0", found, 1);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("midrst_lx", bus_a.joy_lx, 8'h80);
    chk("midrst_settled", bus_a.settled, 1);
    chk("midrst_presc", int'(u_dut_a.presc_q), 0);
    cyc();
    chk("midrst_no_residual", bus_a.joy_lx, 8'h80);

    // TICK_DIV=1, STEP=0xFF instance
    bus_b.dpad_down = 1'b1;
    cyc();
    chk("fast_press_1", bus_b.joy_ly, 8'h80);
    cyc();
    chk("fast_press_2", bus_b.joy_ly, 8'hFF);
    bus_b.dpad_down = 1'b0;
    cyc();
    chk("fast_rel_1", bus_b.joy_ly, 8'hFF);
    cyc();
    chk("fast_rel_2", bus_b.joy_ly, 8'h80);

    // randomized activity against the model
    for (int seg = 0; seg < 80; seg++) begin
      if ($urandom_range(19) == 0) do_reset();
      drive($urandom_range(7) != 0, $urandom_range(1), $urandom_range(1),
            $urandom_range(1), $urandom_range(1));
      n = $urandom_range(40, 1);
      for (int k = 0; k < n; k++) cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpad2analog.md
DPAD2ANALOG -- requirements
Module: dpad2analog

Interface
REQ-001 Parameter CENTER, default 8'h80: analog rest value on both axes.
REQ-002 Parameter STEP, default 8'h10: magnitude added or subtracted per axis per tick; legal range 1..255.
REQ-003 Parameter TICK_DIV, default 16'd4: clk_sys cycles per ramp tick; legal range 1..65535.
REQ-004 clk_sys  input  1  system clock; all logic is on its rising edge.
REQ-005 reset_n  input  1  one clock; reset is synchronous and active-low.
REQ-006 enable  input  1  high = D-pad drives the axes; low = both targets forced to CENTER.
REQ-007 dpad_up, dpad_down, dpad_left, dpad_right  input  1 each  digital D-pad, active high.
REQ-008 joy_lx  output  8  analog X: 0x00 = full left, 0xFF = full right.
REQ-009 joy_ly  output  8  analog Y: 0x00 = full up, 0xFF = full down.
REQ-010 changed  output  1  one-cycle pulse, high in the cycle after either joy_lx or joy_ly took a new value.
REQ-011 settled  output  1  high when both axes equal their current targets.

Function
REQ-012 The block SHALL register enable and the four D-pad inputs once; targets SHALL be computed from the registered copies only.
REQ-013 X target SHALL be 0x00 for left only, 0xFF for right only, and CENTER for neither, both, or enable low. Y uses up and down in the same way.
REQ-014 The prescaler SHALL count 0..TICK_DIV-1 and wrap to 0. tick SHALL be high in the cycle the count equals TICK_DIV-1. With TICK_DIV=1, tick SHALL be high every cycle.
REQ-015 On a tick, each axis SHALL step toward its target:
- below target: value = min(value+STEP, target);
- above target: value = max(value-STEP, target);
- equal: hold.
Arithmetic SHALL be 9-bit, so values never wrap.
REQ-016 Between ticks, axis values SHALL hold.
REQ-017 Each axis SHALL have a state machine:
- states CENTERED, RAMPING, HELD;
- CENTERED -> RAMPING when target != value;
- RAMPING -> HELD when value reaches a target != CENTER;
- RAMPING -> CENTERED when value reaches CENTER;
- HELD or CENTERED -> RAMPING on any target change.
REQ-018 A target change mid-ramp SHALL redirect the ramp on the next tick from the current value, with no restart and no snap.
REQ-019 Latency: an input edge at cycle N SHALL change the target at cycle N+1; the first step SHALL occur on the first tick at or after cycle N+1.
REQ-020 The prescaler SHALL free-run regardless of input activity.
REQ-021 settled SHALL be combinational from the registered values and targets: high iff both axes are in CENTERED or HELD.

Reset
REQ-022 While reset_n is low at a clock edge:
- joy_lx = joy_ly = CENTER;
- changed = 0, settled = 1;
- prescaler = 0;
- input registers = 0;
- both axis states = CENTERED.
REQ-023 A reset asserted mid-ramp SHALL take effect at the next edge with no residual step.

Configuration
REQ-024 Macro DPAD2ANALOG_DIAG_SCALE_EN.
- Defined: when both axes have non-CENTER targets, each target SHALL be CENTER -/+ 0x5B, i.e. 0x25 or 0xDB for CENTER=0x80 (about 0.707 magnitude).
- Undefined: diagonal targets SHALL be the full 0x00 or 0xFF.

Verification
REQ-025 Defaults, right held from reset release: joy_lx steps 0x90, 0xA0 ... 0xF0, then 0xFF on the 8th tick; changed pulses 8 times; settled rises after the 8th step; joy_ly stays 0x80.
REQ-026 Left and right held together: joy_lx stays 0x80 and changed never pulses.
REQ-027 Up held until joy_ly = 0x40, then up released and down pressed in the same cycle: joy_ly goes 0x50, 0x60 ... 0xFF with no return to CENTER first.
REQ-028 Up and right held: macro undefined settles at (0xFF, 0x00); macro defined settles at (0xDB, 0x25) on the 6th tick.
REQ-029 reset_n pulled low for one cycle mid-ramp at joy_lx = 0xB0: the next cycle shows 0x80, settled = 1, prescaler = 0.
REQ-030 TICK_DIV=1, STEP=0xFF, down pressed: joy_ly = 0xFF two cycles after the input edge, and 0x80 two cycles after release.
